apb_reg_decoder: RTL and testbench
==================================

APB_REG_DECODER -- requirements
Module: apb_reg_decoder

Interface
REQ-001 Parameter NUM_REGS, default 8: number of 32-bit word registers decoded, 1..16.
REQ-002 Parameter WAIT_STATES, default 0: extra access cycles inserted before pready, 0..7.
REQ-003 Parameter RD_MASK, default all ones: bit i set means register i is readable.
REQ-004 Parameter WR_MASK, default all ones: bit i set means register i is writable.
REQ-005 Parameter RDSIDE_MASK, default 0: bit i set means a read of register i has a side effect (FIFO pop, status clear).
REQ-006 pclk  in  1  clock; all state changes on the rising edge.
REQ-007 n_rst  in  1  reset, asynchronous, active-low.
REQ-008 paddr  in  32  APB address; only paddr[7:0] decoded.
REQ-009 psel  in  1  APB select.
REQ-010 penable  in  1  APB access phase.
REQ-011 pwrite  in  1  APB direction, 1 = write.
REQ-012 pready  out  1  transfer completes this cycle.
REQ-013 pslverr  out  1  transfer error, valid only with pready.
REQ-014 wr_stb  out  NUM_REGS  one-hot write strobe, asserted with pready.
REQ-015 rd_stb  out  NUM_REGS  one-hot read-data select, held for the whole access phase.
REQ-016 rd_side  out  NUM_REGS  one-cycle side-effect pulse, issued the cycle after read completion.
REQ-017 rd_idx  out  4  index of the register currently being read, for the read-data mux.

Function
REQ-018 The decoder SHALL compute index = paddr[7:2] in the setup cycle (psel=1, penable=0) and register index, pwrite and error flag into the capture registers.
REQ-019 The error flag SHALL be set when paddr[1:0]!=0, index>=NUM_REGS, a write targets a register with WR_MASK=0, or a read targets a register with RD_MASK=0.
REQ-020 The FSM SHALL have states IDLE, ACCESS, ERR_WAIT.
REQ-021 IDLE->ACCESS on psel=1 and penable=0; wait counter loads WAIT_STATES.
REQ-022 In ACCESS with penable=1, the counter SHALL decrement each cycle while nonzero; pready SHALL be 0 while the counter is nonzero.
REQ-023 In ACCESS with the counter at 0 and penable=1, pready SHALL be 1 for exactly one cycle and the FSM SHALL return to IDLE.
REQ-024 On a completing write without error, wr_stb[index] SHALL be 1 in the pready cycle only; all other bits SHALL be 0.
REQ-025 On a read without error, rd_stb[index] SHALL be 1 and rd_idx = index from the first ACCESS cycle through the pready cycle.
REQ-026 rd_side[index] SHALL pulse in the cycle after a completing error-free read only when RDSIDE_MASK[index]=1.
REQ-027 On an error transfer, pslverr SHALL be 1 with pready; no wr_stb, rd_stb or rd_side bit SHALL assert.
REQ-028 Latency: pready SHALL occur in access cycle WAIT_STATES+1, counted from the first penable=1 cycle.
REQ-029 A setup cycle in the cycle after pready (back-to-back transfer) SHALL be accepted without a bubble.
REQ-030 psel dropping to 0 in ACCESS before pready (protocol violation) SHALL abort: the FSM SHALL go to IDLE, with no strobes and no pready.
REQ-031 penable=1 seen in IDLE without a preceding setup cycle SHALL move the FSM to ERR_WAIT; it SHALL give no response and SHALL return to IDLE when penable=0.
REQ-032 pslverr, wr_stb, rd_stb and rd_side SHALL be 0 whenever pready is 0, except the rd_stb hold in REQ-025 and the rd_side pulse in REQ-026.

Reset
REQ-033 While n_rst=0 the state SHALL be IDLE, the counter 0, the capture registers 0, and pready, pslverr, wr_stb, rd_stb, rd_side and rd_idx all 0.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer and suppress any pending rd_side pulse.

Structure
REQ-035 Package apb_reg_pkg SHALL hold the FSM state enum and the constants DEC_ADDR_MSB=7 and IDX_W=4.
REQ-036 A combinational sub-module apb_reg_addr_check SHALL perform the index and error decode of REQ-018 and REQ-019.

Verification
REQ-037 WAIT_STATES=0: write paddr=0x08 -> pready in 2nd bus cycle, wr_stb=8'b00000100 for one cycle, pslverr=0.
REQ-038 WAIT_STATES=2, RDSIDE_MASK=8'h08: read paddr=0x0C -> rd_stb[3]=1 for 3 cycles, pready on the 3rd, rd_side[3] pulse on the next cycle.
REQ-039 WR_MASK=8'hF7: write 0x0C -> pready=1, pslverr=1, wr_stb=0; read paddr=0x22 (misaligned) -> pslverr=1.
REQ-040 NUM_REGS=6: read 0x18 -> pslverr=1, no rd_side; back-to-back write 0x00 then read 0x04 -> two pready pulses with no idle gap.
REQ-041 psel dropped during a WAIT_STATES=3 access -> no pready and no strobes; n_rst pulsed mid-read -> all outputs 0, and the next transfer completes normally.

Source files
------------

// File: rtl/apb_reg_pkg.sv
// Shared types and decode constants for the APB register decoder.
package apb_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_ERR_WAIT = 2'd2
  } state_e;

  localparam int DEC_ADDR_MSB = 7;
  localparam int IDX_W        = 4;

endpackage

// File: rtl/apb_reg_if.sv
// APB completer-side bus bundle used by the register decoder.
interface apb_reg_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic        pready;
  logic        pslverr;

  modport master (output paddr, psel, penable, pwrite, input pready, pslverr);
  modport slave  (input paddr, psel, penable, pwrite, output pready, pslverr);
endinterface

// File: rtl/apb_reg_addr_check.sv
// Combinational word-index extraction and access-permission check.
module apb_reg_addr_check
  import apb_reg_pkg::*;
#(
  parameter int                  NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RD_MASK  = '1,
  parameter logic [NUM_REGS-1:0] WR_MASK  = '1
) (
  input  logic [DEC_ADDR_MSB:0] addr,
  input  logic                  write,
  output logic [IDX_W-1:0]      idx,
  output logic                  err
);

  localparam int                  WORD_W  = DEC_ADDR_MSB - 1;
  localparam logic [WORD_W-1:0]   NUM_W   = WORD_W'(NUM_REGS);
  localparam logic [15:0]         RD_EXT  = 16'(RD_MASK);
  localparam logic [15:0]         WR_EXT  = 16'(WR_MASK);

  logic [WORD_W-1:0] word;
  logic              in_range;
  logic              perm;

  always_comb begin
    word     = addr[DEC_ADDR_MSB:2];
    idx      = word[IDX_W-1:0];
    in_range = (word < NUM_W);
    // idx is only meaningful when in range, so the permission lookup can use the truncated index
    perm     = write ? WR_EXT[idx] : RD_EXT[idx];
    err      = (addr[1:0] != 2'b00) || !in_range || !perm;
  end

endmodule

// File: rtl/apb_reg_decoder.sv
// APB register decoder: setup-phase capture, wait-state counter, strobes and read side-effect pulse.
module apb_reg_decoder
  import apb_reg_pkg::*;
#(
  parameter int                  NUM_REGS    = 8,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RD_MASK     = '1,
  parameter logic [NUM_REGS-1:0] WR_MASK     = '1,
  parameter logic [NUM_REGS-1:0] RDSIDE_MASK = '0
) (
  input  logic                pclk,
  input  logic                n_rst,
  apb_reg_if.slave            bus,
  output logic [NUM_REGS-1:0] wr_stb,
  output logic [NUM_REGS-1:0] rd_stb,
  output logic [NUM_REGS-1:0] rd_side,
  output logic [IDX_W-1:0]    rd_idx
);

  localparam logic [2:0]  WAIT_LD  = 3'(WAIT_STATES);
  localparam logic [15:0] SIDE_EXT = 16'(RDSIDE_MASK);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] rd_side_q, rd_side_d;
  logic [NUM_REGS-1:0] idx_oh;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_err;
  logic                pready_c, pslverr_c;
  logic                unused_hi;

  assign unused_hi = ^bus.paddr[31:DEC_ADDR_MSB+1];

  apb_reg_addr_check #(
    .NUM_REGS (NUM_REGS),
    .RD_MASK  (RD_MASK),
    .WR_MASK  (WR_MASK)
  ) u_addr_check (
    .addr  (bus.paddr[DEC_ADDR_MSB:0]),
    .write (bus.pwrite),
    .idx   (dec_idx),
    .err   (dec_err)
  );

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      idx_oh[i] = (idx_q == IDX_W'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    err_d     = err_q;
    rd_side_d = '0;
    pready_c  = 1'b0;
    pslverr_c = 1'b0;
    wr_stb    = '0;
    rd_stb    = '0;
    rd_idx    = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.penable) begin
          state_d = ST_ERR_WAIT;
        end else if (bus.psel) begin
          state_d = ST_ACCESS;
          cnt_d   = WAIT_LD;
          idx_d   = dec_idx;
          wr_d    = bus.pwrite;
          err_d   = dec_err;
        end
      end
      ST_ACCESS: begin
        if (!bus.psel) begin
          // master abandoned the transfer: drop it silently
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          if (!wr_q && !err_q) begin
            rd_stb = idx_oh;
            rd_idx = idx_q;
          end
          if (bus.penable) begin
            if (cnt_q != 3'd0) begin
              cnt_d = cnt_q - 3'd1;
            end else begin
              state_d   = ST_IDLE;
              pready_c  = 1'b1;
              pslverr_c = err_q;
              if (wr_q && !err_q) wr_stb = idx_oh;
              if (!wr_q && !err_q && SIDE_EXT[idx_q]) rd_side_d = idx_oh;
            end
          end
        end
      end
      ST_ERR_WAIT: begin
        if (!bus.penable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_side_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      rd_side_q <= rd_side_d;
    end
  end

  assign bus.pready  = pready_c;
  assign bus.pslverr = pslverr_c;
  assign rd_side     = rd_side_q;

endmodule

// File: tb/tb_apb_reg_decoder.sv
// Self-checking bench: three decoder configurations driven one at a time against a rule-based model.
module tb_apb_reg_decoder;

  logic pclk;
  logic n_rst;

  logic [2:0][31:0] a_addr;
  logic [2:0]       a_sel, a_en, a_wr;
  logic [2:0]       a_rdy, a_err;
  logic [2:0][15:0] o_wr, o_rd, o_side;
  logic [2:0][3:0]  o_idx;

  logic [7:0] wr0, rd0, sd0, wr1, rd1, sd1;
  logic [5:0] wr2, rd2, sd2;

  int cfg_num  [3] = '{8, 8, 6};
  int cfg_wait [3] = '{0, 2, 3};
  int cfg_rd   [3] = '{'hFF, 'hDF, 'h3F};
  int cfg_wr   [3] = '{'hF7, 'hFF, 'h3F};
  int cfg_side [3] = '{'h00, 'h08, 'h21};

  int n_chk;
  int n_fail;
  logic [2:0][15:0] pend_side;

  apb_reg_if bus0 ();
  apb_reg_if bus1 ();
  apb_reg_if bus2 ();

  assign bus0.paddr = a_addr[0]; assign bus0.psel = a_sel[0]; assign bus0.penable = a_en[0]; assign bus0.pwrite = a_wr[0];
  assign bus1.paddr = a_addr[1]; assign bus1.psel = a_sel[1]; assign bus1.penable = a_en[1]; assign bus1.pwrite = a_wr[1];
  assign bus2.paddr = a_addr[2]; assign bus2.psel = a_sel[2]; assign bus2.penable = a_en[2]; assign bus2.pwrite = a_wr[2];
  assign a_rdy = {bus2.pready, bus1.pready, bus0.pready};
  assign a_err = {bus2.pslverr, bus1.pslverr, bus0.pslverr};
  assign o_wr[0] = {8'b0, wr0};  assign o_rd[0] = {8'b0, rd0};  assign o_side[0] = {8'b0, sd0};
  assign o_wr[1] = {8'b0, wr1};  assign o_rd[1] = {8'b0, rd1};  assign o_side[1] = {8'b0, sd1};
  assign o_wr[2] = {10'b0, wr2}; assign o_rd[2] = {10'b0, rd2}; assign o_side[2] = {10'b0, sd2};

  apb_reg_decoder #(.NUM_REGS(8), .WAIT_STATES(0), .RD_MASK(8'hFF), .WR_MASK(8'hF7), .RDSIDE_MASK(8'h00)) dut0 (
    .pclk(pclk), .n_rst(n_rst), .bus(bus0), .wr_stb(wr0), .rd_stb(rd0), .rd_side(sd0), .rd_idx(o_idx[0]));
  apb_reg_decoder #(.NUM_REGS(8), .WAIT_STATES(2), .RD_MASK(8'hDF), .WR_MASK(8'hFF), .RDSIDE_MASK(8'h08)) dut1 (
    .pclk(pclk), .n_rst(n_rst), .bus(bus1), .wr_stb(wr1), .rd_stb(rd1), .rd_side(sd1), .rd_idx(o_idx[1]));
  apb_reg_decoder #(.NUM_REGS(6), .WAIT_STATES(3), .RD_MASK(6'h3F), .WR_MASK(6'h3F), .RDSIDE_MASK(6'h21)) dut2 (
    .pclk(pclk), .n_rst(n_rst), .bus(bus2), .wr_stb(wr2), .rd_stb(rd2), .rd_side(sd2), .rd_idx(o_idx[2]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic bit model_err(int d, logic [31:0] a, bit wr);
    int w;
    w = int'(a[7:2]);
    if (a[1:0] != 2'b00) return 1'b1;
    if (w >= cfg_num[d]) return 1'b1;
    if (wr) return ((cfg_wr[d] >> w) & 1) == 0;
    return ((cfg_rd[d] >> w) & 1) == 0;
  endfunction

  // One complete transfer on DUT d; leaves the bus driving idle unless chained.
  task automatic run_xfer(input int d, input logic [31:0] addr, input bit wr, input bit b2b);
    bit          err;
    int          idx, last;
    logic [15:0] oh, e_wr, e_rd;
    logic [3:0]  e_idx;
    err  = model_err(d, addr, wr);
    idx  = int'(addr[7:2]);
    oh   = err ? 16'h0 : (16'h1 << idx);
    last = cfg_wait[d] + 1;
    a_sel[d] = 1'b1; a_en[d] = 1'b0; a_addr[d] = addr; a_wr[d] = wr;
    @(negedge pclk);
    n_chk++;
    if (a_rdy[d] !== 1'b0 || o_wr[d] !== 16'h0 || o_rd[d] !== 16'h0 || o_side[d] !== pend_side[d]) begin
      n_fail++;
      $display("FAIL setup d%0d addr=%h: rdy=%b wr=%h rd=%h side=%h, expected rdy=0 wr=0 rd=0 side=%h",
               d, addr, a_rdy[d], o_wr[d], o_rd[d], o_side[d], pend_side[d]);
    end
    pend_side[d] = 16'h0;
    @(posedge pclk); #1;
    a_en[d] = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge pclk);
      e_wr  = (c == last && wr) ? oh : 16'h0;
      e_rd  = wr ? 16'h0 : oh;
      e_idx = (!wr && !err) ? 4'(idx) : 4'h0;
      n_chk++;
      if (a_rdy[d] !== (c == last) || a_err[d] !== (c == last && err)) begin
        n_fail++;
        $display("FAIL handshake d%0d addr=%h wr=%0b cyc%0d: pready=%b pslverr=%b, expected %b %b",
                 d, addr, wr, c, a_rdy[d], a_err[d], (c == last), (c == last && err));
      end
      n_chk++;
      if (o_wr[d] !== e_wr || o_rd[d] !== e_rd || o_idx[d] !== e_idx || o_side[d] !== 16'h0) begin
        n_fail++;
        $display("FAIL strobes d%0d addr=%h wr=%0b cyc%0d: wr=%h rd=%h idx=%h side=%h, expected wr=%h rd=%h idx=%h side=0",
                 d, addr, wr, c, o_wr[d], o_rd[d], o_idx[d], o_side[d], e_wr, e_rd, e_idx);
      end
      @(posedge pclk); #1;
    end
    pend_side[d] = (!wr && !err && ((cfg_side[d] >> idx) & 1) == 1) ? oh : 16'h0;
    if (!b2b) begin
      a_sel[d] = 1'b0; a_en[d] = 1'b0;
      @(negedge pclk);
      n_chk++;
      if (a_rdy[d] !== 1'b0 || a_err[d] !== 1'b0 || o_wr[d] !== 16'h0 || o_rd[d] !== 16'h0 ||
          o_side[d] !== pend_side[d]) begin
        n_fail++;
        $display("FAIL post d%0d addr=%h: rdy=%b err=%b wr=%h rd=%h side=%h, expected side=%h rest 0",
                 d, addr, a_rdy[d], a_err[d], o_wr[d], o_rd[d], o_side[d], pend_side[d]);
      end
      pend_side[d] = 16'h0;
      @(posedge pclk); #1;
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    a_sel = '0; a_en = '0; a_wr = '0; a_addr = '0;
    pend_side = '0;
    #12;
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (a_rdy[d] !== 1'b0 || a_err[d] !== 1'b0 || o_wr[d] !== 16'h0 || o_rd[d] !== 16'h0 ||
          o_side[d] !== 16'h0 || o_idx[d] !== 4'h0) begin
        n_fail++;
        $display("FAIL reset d%0d: rdy=%b err=%b wr=%h rd=%h side=%h idx=%h, expected all 0",
                 d, a_rdy[d], a_err[d], o_wr[d], o_rd[d], o_side[d], o_idx[d]);
      end
    end
    @(posedge pclk); #1;
    n_rst = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic test_directed();
    run_xfer(0, 32'h08, 1'b1, 1'b0);
    run_xfer(1, 32'h0C, 1'b0, 1'b0);
    run_xfer(0, 32'h0C, 1'b1, 1'b0);
    run_xfer(0, 32'h22, 1'b0, 1'b0);
    run_xfer(2, 32'h18, 1'b0, 1'b0);
    run_xfer(1, 32'h14, 1'b0, 1'b0);
    run_xfer(2, 32'hFFFF_FF14, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_xfer(2, 32'h00, 1'b1, 1'b1);
    run_xfer(2, 32'h04, 1'b0, 1'b0);
    run_xfer(1, 32'h0C, 1'b0, 1'b1);
    run_xfer(1, 32'h0C, 1'b1, 1'b1);
    run_xfer(1, 32'h1C, 1'b0, 1'b0);
    run_xfer(0, 32'h00, 1'b0, 1'b1);
    run_xfer(0, 32'h1C, 1'b1, 1'b0);
  endtask

  task automatic test_err_wait();
    a_sel[0] = 1'b1; a_en[0] = 1'b1; a_addr[0] = 32'h08; a_wr[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      n_chk++;
      if (a_rdy[0] !== 1'b0 || a_err[0] !== 1'b0 || o_wr[0] !== 16'h0 || o_rd[0] !== 16'h0) begin
        n_fail++;
        $display("FAIL err_wait cyc%0d: rdy=%b err=%b wr=%h rd=%h, expected all 0",
                 c, a_rdy[0], a_err[0], o_wr[0], o_rd[0]);
      end
      @(posedge pclk); #1;
    end
    a_sel[0] = 1'b0; a_en[0] = 1'b0;
    @(posedge pclk); #1;
    run_xfer(0, 32'h08, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    for (int k = 0; k < 2; k++) begin
      a_sel[2] = 1'b1; a_en[2] = 1'b0; a_wr[2] = (k == 1); a_addr[2] = (k == 1) ? 32'h04 : 32'h00;
      @(posedge pclk); #1;
      a_en[2] = 1'b1;
      for (int c = 0; c < 2; c++) begin
        @(negedge pclk);
        n_chk++;
        if (a_rdy[2] !== 1'b0 || o_wr[2] !== 16'h0 || o_rd[2] !== ((k == 1) ? 16'h0 : 16'h1)) begin
          n_fail++;
          $display("FAIL abort_hold k%0d cyc%0d: rdy=%b wr=%h rd=%h", k, c, a_rdy[2], o_wr[2], o_rd[2]);
        end
        @(posedge pclk); #1;
      end
      a_sel[2] = 1'b0; a_en[2] = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge pclk);
        n_chk++;
        if (a_rdy[2] !== 1'b0 || a_err[2] !== 1'b0 || o_wr[2] !== 16'h0 || o_rd[2] !== 16'h0 || o_side[2] !== 16'h0) begin
          n_fail++;
          $display("FAIL abort_after k%0d cyc%0d: rdy=%b err=%b wr=%h rd=%h side=%h, expected all 0",
                   k, c, a_rdy[2], a_err[2], o_wr[2], o_rd[2], o_side[2]);
        end
        @(posedge pclk); #1;
      end
    end
    run_xfer(2, 32'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    a_sel[1] = 1'b1; a_en[1] = 1'b0; a_wr[1] = 1'b0; a_addr[1] = 32'h0C;
    @(posedge pclk); #1;
    a_en[1] = 1'b1;
    @(posedge pclk); #1;
    n_rst = 1'b0; a_sel[1] = 1'b0; a_en[1] = 1'b0;
    @(negedge pclk);
    n_chk++;
    if (a_rdy[1] !== 1'b0 || o_rd[1] !== 16'h0 || o_idx[1] !== 4'h0 || o_side[1] !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid: rdy=%b rd=%h idx=%h side=%h, expected all 0", a_rdy[1], o_rd[1], o_idx[1], o_side[1]);
    end
    @(posedge pclk); #1;
    n_rst = 1'b1;
    @(posedge pclk); #1;
    run_xfer(1, 32'h0C, 1'b0, 1'b1);
    n_rst = 1'b0; a_sel[1] = 1'b0; a_en[1] = 1'b0;
    pend_side[1] = 16'h0;
    @(negedge pclk);
    n_chk++;
    if (o_side[1] !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_side: rd_side=%h, expected 0", o_side[1]);
    end
    @(posedge pclk); #1;
    n_rst = 1'b1;
    @(posedge pclk); #1;
    run_xfer(1, 32'h08, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          w;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 40; n++) begin
        w = $urandom_range(0, cfg_num[d] + 1);
        a = {$urandom_range(0, 32'hFF_FFFF), 8'h00};
        a[7:2] = 6'(w);
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        run_xfer(d, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      a_sel[d] = 1'b0; a_en[d] = 1'b0;
      @(negedge pclk);
      n_chk++;
      if (o_side[d] !== pend_side[d] || a_rdy[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL random_tail d%0d: side=%h rdy=%b, expected side=%h rdy=0", d, o_side[d], a_rdy[d], pend_side[d]);
      end
      pend_side[d] = 16'h0;
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_err_wait();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
